// File: rtl/mesh_link_buf.sv
// mesh_link_buf: registered point-to-point link between two mesh tiles.
// Each direction (AB, BA) has its own DEPTH-entry FIFO.
// A sender is accepted based only on that FIFO's registered occupancy, so no
// combinational path runs from one tile to the other.
// Optional feature macro: MESH_LINK_STATS_EN adds saturating pop counters
// on xfer_AB / xfer_BA.

// One direction of the link: circular buffer with an explicit occupancy count.
module mesh_link_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_req,
  input  logic [WIDTH-1:0]             push_data,
  output logic                         push_done,
  input  logic                         pop_req,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         pop_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;

  // Handshakes use registered occupancy only; a same-cycle pop does not free
  // space for a push and a same-cycle push does not make data poppable.
  // Both are forced low while reset is asserted.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push_done = rst_n & push_req & ~full;
  assign pop_valid = rst_n & pop_req & ~empty;
  assign pop_data  = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap by compare so any DEPTH works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_done)
        wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop_valid)
        rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      if (push_done && !pop_valid)
        count <= count + CW'(1);
      else if (!push_done && pop_valid)
        count <= count - CW'(1);
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_done)
      mem[wr_ptr] <= push_data;
  end

endmodule

module mesh_link_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [WIDTH-1:0]            send_data_A,
  input  logic                        send_ready_A,
  output logic                        send_done_A,
  input  logic                        recv_ready_A,
  output logic [WIDTH-1:0]            recv_data_A,
  output logic                        recv_valid_A,
  input  logic [WIDTH-1:0]            send_data_B,
  input  logic                        send_ready_B,
  output logic                        send_done_B,
  input  logic                        recv_ready_B,
  output logic [WIDTH-1:0]            recv_data_B,
  output logic                        recv_valid_B,
  output logic [$clog2(DEPTH+1)-1:0]  count_AB,
  output logic [$clog2(DEPTH+1)-1:0]  count_BA
`ifdef MESH_LINK_STATS_EN
  ,
  output logic [CNT_W-1:0]            xfer_AB,
  output logic [CNT_W-1:0]            xfer_BA
`endif
);

  // Reject configurations outside the supported range at elaboration.
  if (DEPTH < 2 || DEPTH > 64 || CNT_W < 1) begin : g_bad_cfg
    $error("mesh_link_buf: DEPTH must be 2..64 and CNT_W at least 1");
  end

  mesh_link_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ab (
    .clk       (CLK),
    .rst_n     (nRST),
    .push_req  (send_ready_A),
    .push_data (send_data_A),
    .push_done (send_done_A),
    .pop_req   (recv_ready_B),
    .pop_data  (recv_data_B),
    .pop_valid (recv_valid_B),
    .count     (count_AB)
  );

  mesh_link_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ba (
    .clk       (CLK),
    .rst_n     (nRST),
    .push_req  (send_ready_B),
    .push_data (send_data_B),
    .push_done (send_done_B),
    .pop_req   (recv_ready_A),
    .pop_data  (recv_data_A),
    .pop_valid (recv_valid_A),
    .count     (count_BA)
  );

`ifdef MESH_LINK_STATS_EN
  // Saturating pop counters, one per direction.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      xfer_AB <= '0;
      xfer_BA <= '0;
    end else begin
      if (recv_valid_B && (xfer_AB != '1))
        xfer_AB <= xfer_AB + CNT_W'(1);
      if (recv_valid_A && (xfer_BA != '1))
        xfer_BA <= xfer_BA + CNT_W'(1);
    end
  end
`endif

endmodule
